elevator_scan_ctrl: RTL

//  Parametrised N-floor elevator controller, successor to the 4-floor single-request

---
 rtl/elevator_pkg.sv | 24 ++
 rtl/elevator_req_scan.sv | 28 ++
 rtl/elevator_scan_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state encoding and floor mask helpers for the SCAN elevator
package elevator_pkg;

    localparam int STATE_W    = 3;
    localparam int MAX_FLOORS = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR_OPEN,
        ST_EMERGENCY
    } state_t;

    // Floors strictly above `floor`; the shift overflows to zero for the top floor.
    function automatic logic [MAX_FLOORS-1:0] above_mask(input int unsigned floor);
        return ~((64'd2 << floor) - 64'd1);
    endfunction

    function automatic logic [MAX_FLOORS-1:0] below_mask(input int unsigned floor);
        return (64'd1 << floor) - 64'd1;
    endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// rtl/elevator_req_scan.sv - classifies pending requests as here / above / below a floor
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending_req,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic                  req_here,
    output logic                  req_above,
    output logic                  req_below
);

    logic [MAX_FLOORS-1:0] above_m;
    logic [MAX_FLOORS-1:0] below_m;
    logic [NUM_FLOORS-1:0] here_m;

    always_comb begin
        above_m   = above_mask(32'(current_floor));
        below_m   = below_mask(32'(current_floor));
        here_m    = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << current_floor;
        req_here  = |(pending_req & here_m);
        req_above = |(pending_req & above_m[NUM_FLOORS-1:0]);
        req_below = |(pending_req & below_m[NUM_FLOORS-1:0]);
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - N-floor SCAN elevator controller with travel/door timing and emergency hold
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] floor_req,
    input  logic                  emergency_stop,
    output logic                  move_up,
    output logic                  move_down,
    output logic                  motor_stop,
    output logic                  door_open,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending_req
);

    localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
    localparam int DOOR_W   = $clog2(DOOR_CYCLES + 1);
    localparam logic [TRAVEL_W-1:0]   TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]     DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] FLOOR_ONE   = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_up_q, dir_up_d;
    logic [TRAVEL_W-1:0]   travel_q, travel_d;
    logic [DOOR_W-1:0]     door_q, door_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] served_mask;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  req_here, req_above, req_below;
    logic                  nf_here, nf_above, nf_below;

    elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_cur (
        .pending_req   (pending_q),
        .current_floor (floor_q),
        .req_here      (req_here),
        .req_above     (req_above),
        .req_below     (req_below)
    );

    // Second view of the same requests from the floor the car is about to reach.
    elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_next (
        .pending_req   (pending_q),
        .current_floor (next_floor),
        .req_here      (nf_here),
        .req_above     (nf_above),
        .req_below     (nf_below)
    );

    always_comb begin
        next_floor = (state_q == ST_MOVE_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        dir_up_d    = dir_up_q;
        travel_d    = travel_q;
        door_d      = door_q;
        served_mask = '0;

        if (emergency_stop) begin
            state_d  = ST_EMERGENCY;
            travel_d = '0;
            door_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_here) begin
                        state_d     = ST_DOOR_OPEN;
                        served_mask = FLOOR_ONE << floor_q;
                    end else if (dir_up_q && req_above) begin
                        state_d = ST_MOVE_UP;
                    end else if (!dir_up_q && req_below) begin
                        state_d = ST_MOVE_DOWN;
                    end else if (req_above) begin
                        state_d  = ST_MOVE_UP;
                        dir_up_d = 1'b1;
                    end else if (req_below) begin
                        state_d  = ST_MOVE_DOWN;
                        dir_up_d = 1'b0;
                    end
                end
                ST_MOVE_UP, ST_MOVE_DOWN: begin
                    if (travel_q == TRAVEL_LAST) begin
                        travel_d = '0;
                        floor_d  = next_floor;
                        if (nf_here) begin
                            state_d     = ST_DOOR_OPEN;
                            served_mask = FLOOR_ONE << next_floor;
                        end else if ((state_q == ST_MOVE_UP) ? !nf_above : !nf_below) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        travel_d = travel_q + TRAVEL_W'(1);
                    end
                end
                ST_DOOR_OPEN: begin
                    // Calls for this floor are absorbed while the door is already open.
                    served_mask = FLOOR_ONE << floor_q;
                    if (door_q == DOOR_LAST) begin
                        door_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        door_d = door_q + DOOR_W'(1);
                    end
                end
                ST_EMERGENCY: state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end

        pending_d = (pending_q | floor_req) & ~served_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            travel_q  <= '0;
            door_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            travel_q  <= travel_d;
            door_q    <= door_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        move_up       = (state_q == ST_MOVE_UP);
        move_down     = (state_q == ST_MOVE_DOWN);
        door_open     = (state_q == ST_DOOR_OPEN);
        motor_stop    = !(move_up || move_down);
        current_floor = floor_q;
        pending_req   = pending_q;
    end

endmodule
